// File: rtl/yutorina_bus_if_pkg.sv
// Shared definitions for the yutorina memory-access initiator: widths, SPM region,
// active-low enable levels, access direction codes and the bus FSM state encoding.
package yutorina_bus_if_pkg;

    localparam int DEF_ADDR_W     = 30;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_SPM_ADDR_W = 12;

    localparam int REGION_W = 3;
    localparam logic [REGION_W-1:0] DEF_SPM_REGION = 3'b011;

    localparam logic YUTORINA_ENABLE_  = 1'b0;
    localparam logic YUTORINA_DISABLE_ = 1'b1;
    localparam logic YUTORINA_READ     = 1'b1;
    localparam logic YUTORINA_WRITE    = 1'b0;

    typedef enum logic [1:0] {
        BUS_IF_IDLE    = 2'd0,
        BUS_IF_REQUEST = 2'd1,
        BUS_IF_ACCESS  = 2'd2,
        BUS_IF_STALL   = 2'd3
    } bus_if_state_e;

    // The top address bits select the target memory region.
    function automatic logic region_hit(input logic [REGION_W-1:0] region,
                                        input logic [REGION_W-1:0] target);
        return (region == target);
    endfunction

endpackage

// File: rtl/yutorina_bus_if.sv
// Memory-access initiator: SPM accesses go straight to the scratchpad port, all
// other accesses run the request/grant/strobe/ready handshake on the external bus.
module yutorina_bus_if
    import yutorina_bus_if_pkg::*;
#(
    parameter int ADDR_W                   = DEF_ADDR_W,
    parameter int DATA_W                   = DEF_DATA_W,
    parameter int SPM_ADDR_W               = DEF_SPM_ADDR_W,
    parameter logic [REGION_W-1:0] SPM_REGION = DEF_SPM_REGION
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  address_strobe_,
    input  logic                  read_write,
    input  logic [DATA_W-1:0]     write_data,
    output logic [DATA_W-1:0]     read_data,
    output logic                  busy,
    output logic [SPM_ADDR_W-1:0] spm_address,
    output logic                  spm_address_strobe_,
    output logic                  spm_read_write,
    output logic [DATA_W-1:0]     spm_write_data,
    input  logic [DATA_W-1:0]     spm_read_data,
    output logic                  bus_request_,
    input  logic                  bus_grant_,
    output logic [ADDR_W-1:0]     bus_address,
    output logic                  bus_address_strobe_,
    output logic                  bus_read_write,
    output logic [DATA_W-1:0]     bus_write_data,
    input  logic [DATA_W-1:0]     bus_read_data,
    input  logic                  bus_ready_
);

    bus_if_state_e     state_r;
    bus_if_state_e     next_state_s;
    logic [DATA_W-1:0] rd_buf_r;
    logic              spm_hit_s;
    logic              access_s;
    logic              launch_s;

    assign spm_hit_s      = region_hit(address[ADDR_W-1 -: REGION_W], SPM_REGION);
    assign access_s       = (address_strobe_ == YUTORINA_ENABLE_) && !flush;
    assign launch_s       = access_s && !spm_hit_s;
    assign spm_address    = address[SPM_ADDR_W-1:0];
    assign spm_read_write = read_write;
    assign spm_write_data = write_data;

    // Next-state decode plus the combinational read_data/busy/SPM strobe outputs.
    always_comb begin
        next_state_s        = state_r;
        read_data           = '0;
        busy                = 1'b0;
        spm_address_strobe_ = YUTORINA_DISABLE_;
        case (state_r)
            BUS_IF_IDLE: begin
                if (spm_hit_s) begin
                    // SPM registers its address, so this word answers last cycle's access.
                    read_data = spm_read_data;
                    if (access_s) begin
                        spm_address_strobe_ = YUTORINA_ENABLE_;
                    end else begin
                        spm_address_strobe_ = YUTORINA_DISABLE_;
                    end
                end else if (launch_s) begin
                    busy         = 1'b1;
                    next_state_s = BUS_IF_REQUEST;
                end else begin
                    busy = 1'b0;
                end
            end
            BUS_IF_REQUEST: begin
                busy = 1'b1;
                if (flush) begin
                    next_state_s = BUS_IF_IDLE;
                end else if (bus_grant_ == YUTORINA_ENABLE_) begin
                    next_state_s = BUS_IF_ACCESS;
                end else begin
                    next_state_s = BUS_IF_REQUEST;
                end
            end
            BUS_IF_ACCESS: begin
                if (bus_ready_ == YUTORINA_ENABLE_) begin
                    read_data    = bus_read_data;
                    busy         = 1'b0;
                    next_state_s = stall ? BUS_IF_STALL : BUS_IF_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            BUS_IF_STALL: begin
                read_data = rd_buf_r;
                if (!stall) begin
                    next_state_s = BUS_IF_IDLE;
                end else begin
                    next_state_s = BUS_IF_STALL;
                end
            end
            default: begin
                next_state_s = BUS_IF_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= BUS_IF_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered bus-side outputs and the read buffer that serves STALL.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus_request_        <= YUTORINA_DISABLE_;
            bus_address_strobe_ <= YUTORINA_DISABLE_;
            bus_address         <= '0;
            bus_read_write      <= YUTORINA_READ;
            bus_write_data      <= '0;
            rd_buf_r            <= '0;
        end else begin
            case (state_r)
                BUS_IF_IDLE: begin
                    if (launch_s) begin
                        bus_request_   <= YUTORINA_ENABLE_;
                        bus_address    <= address;
                        bus_read_write <= read_write;
                        bus_write_data <= write_data;
                    end
                end
                BUS_IF_REQUEST: begin
                    if (flush) begin
                        bus_request_ <= YUTORINA_DISABLE_;
                    end else if (bus_grant_ == YUTORINA_ENABLE_) begin
                        bus_address_strobe_ <= YUTORINA_ENABLE_;
                    end
                end
                BUS_IF_ACCESS: begin
                    // An issued transfer always completes; flush has no say here.
                    if (bus_ready_ == YUTORINA_ENABLE_) begin
                        bus_request_        <= YUTORINA_DISABLE_;
                        bus_address_strobe_ <= YUTORINA_DISABLE_;
                        if (bus_read_write == YUTORINA_READ) begin
                            rd_buf_r <= bus_read_data;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yutorina_bus_if.sv
// Directed self-checking bench for yutorina_bus_if: a vector table for the IDLE
// decode plus hand-written multi-cycle bus sequences.
module tb_yutorina_bus_if;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [29:0] address = 30'h0;
    logic        address_strobe_ = 1'b1;
    logic        read_write = RD;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        busy;
    logic [11:0] spm_address;
    logic        spm_address_strobe_;
    logic        spm_read_write;
    logic [31:0] spm_write_data;
    logic [31:0] spm_read_data = 32'h0;
    logic        bus_request_;
    logic        bus_grant_ = 1'b1;
    logic [29:0] bus_address;
    logic        bus_address_strobe_;
    logic        bus_read_write;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data = 32'h0;
    logic        bus_ready_ = 1'b1;

    int checks = 0;
    int errors = 0;

    yutorina_bus_if dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .address(address), .address_strobe_(address_strobe_),
        .read_write(read_write), .write_data(write_data),
        .read_data(read_data), .busy(busy),
        .spm_address(spm_address), .spm_address_strobe_(spm_address_strobe_),
        .spm_read_write(spm_read_write), .spm_write_data(spm_write_data),
        .spm_read_data(spm_read_data),
        .bus_request_(bus_request_), .bus_grant_(bus_grant_),
        .bus_address(bus_address), .bus_address_strobe_(bus_address_strobe_),
        .bus_read_write(bus_read_write), .bus_write_data(bus_write_data),
        .bus_read_data(bus_read_data), .bus_ready_(bus_ready_)
    );

    always #5 clock = ~clock;

    // Scratchpad model: one word preloaded, read data registered on the strobe.
    always @(posedge clock) begin
        if (!spm_address_strobe_ && spm_read_write) begin
            spm_read_data <= (spm_address == 12'h010) ? 32'hDEADBEEF : 32'h00000000;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [29:0] addr;
        logic        as_n;
        logic        rw;
        logic        fl;
        logic        st;
        logic        exp_spm_as_n;
        logic        exp_busy;
        logic [11:0] exp_spm_addr;
    } vec_t;

    vec_t vecs[8];
    int   busy_cycles;

    initial begin
        vecs[0] = '{30'h18000010, 1'b0, RD, 1'b0, 1'b0, 1'b0, 1'b0, 12'h010};
        vecs[1] = '{30'h18000010, 1'b0, RD, 1'b1, 1'b0, 1'b1, 1'b0, 12'h010};
        vecs[2] = '{30'h00000040, 1'b0, WR, 1'b0, 1'b0, 1'b1, 1'b1, 12'h040};
        vecs[3] = '{30'h00000040, 1'b0, RD, 1'b1, 1'b1, 1'b1, 1'b0, 12'h040};
        vecs[4] = '{30'h00000040, 1'b1, RD, 1'b0, 1'b0, 1'b1, 1'b0, 12'h040};
        vecs[5] = '{30'h10000FFF, 1'b0, RD, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF};
        vecs[6] = '{30'h1FFFFFFF, 1'b0, WR, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF};
        vecs[7] = '{30'h20000123, 1'b0, RD, 1'b0, 1'b1, 1'b1, 1'b1, 12'h123};

        // Reset state
        tick(); tick();
        @(negedge clock);
        chk("rst_req", {31'h0, bus_request_}, 32'h1);
        chk("rst_bas", {31'h0, bus_address_strobe_}, 32'h1);
        chk("rst_baddr", {2'b00, bus_address}, 32'h0);
        chk("rst_bwd", bus_write_data, 32'h0);
        chk("rst_brw", {31'h0, bus_read_write}, {31'h0, RD});
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_rdata", read_data, 32'h0);

        // IDLE decode table; reset on the following edge so nothing launches.
        for (int i = 0; i < 8; i++) begin
            address = vecs[i].addr; address_strobe_ = vecs[i].as_n;
            read_write = vecs[i].rw; flush = vecs[i].fl; stall = vecs[i].st;
            write_data = 32'hA5A50000 + 32'(i);
            reset = 1'b0;
            @(negedge clock);
            chk($sformatf("v%0d_spm_as", i), {31'h0, spm_address_strobe_}, {31'h0, vecs[i].exp_spm_as_n});
            chk($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].exp_busy});
            chk($sformatf("v%0d_spm_addr", i), {20'h0, spm_address}, {20'h0, vecs[i].exp_spm_addr});
            chk($sformatf("v%0d_spm_rw", i), {31'h0, spm_read_write}, {31'h0, vecs[i].rw});
            chk($sformatf("v%0d_spm_wd", i), spm_write_data, 32'hA5A50000 + 32'(i));
            reset = 1'b1;
            tick();
        end
        reset = 1'b0; flush = 1'b0; stall = 1'b0; address_strobe_ = 1'b1;
        tick();

        // SPM read: strobe this cycle, data next cycle, bus untouched.
        address = 30'h18000010; address_strobe_ = 1'b0; read_write = RD;
        @(negedge clock);
        chk("spm_as", {31'h0, spm_address_strobe_}, 32'h0);
        chk("spm_addr", {20'h0, spm_address}, 32'h010);
        chk("spm_busy0", {31'h0, busy}, 32'h0);
        tick();
        address_strobe_ = 1'b1;
        @(negedge clock);
        chk("spm_rdata", read_data, 32'hDEADBEEF);
        chk("spm_busy1", {31'h0, busy}, 32'h0);
        chk("spm_req", {31'h0, bus_request_}, 32'h1);
        tick();

        // Bus write: grant 3 cycles after request, ready on 3rd access cycle.
        busy_cycles = 0;
        for (int c = 0; c < 8; c++) begin
            address = 30'h00000040; write_data = 32'h12345678; read_write = WR;
            address_strobe_ = (c == 0) ? 1'b0 : 1'b1;
            bus_grant_ = (c >= 3) ? 1'b0 : 1'b1;
            bus_ready_ = (c == 6) ? 1'b0 : 1'b1;
            @(negedge clock);
            if (busy) busy_cycles++;
            if (c == 1) begin
                chk("bw_req", {31'h0, bus_request_}, 32'h0);
                chk("bw_addr", {2'b00, bus_address}, 32'h00000040);
                chk("bw_wd", bus_write_data, 32'h12345678);
                chk("bw_rw", {31'h0, bus_read_write}, {31'h0, WR});
            end
            if (c == 3) chk("bw_as_pre", {31'h0, bus_address_strobe_}, 32'h1);
            if (c == 4) chk("bw_as", {31'h0, bus_address_strobe_}, 32'h0);
            if (c == 7) begin
                chk("bw_rel_req", {31'h0, bus_request_}, 32'h1);
                chk("bw_rel_as", {31'h0, bus_address_strobe_}, 32'h1);
            end
            tick();
        end
        chk("bw_busy_cycles", busy_cycles, 32'd6);
        bus_grant_ = 1'b1; bus_ready_ = 1'b1;

        // Bus read with stall held through ready; stray strobe in STALL is ignored.
        for (int c = 0; c < 8; c++) begin
            address = 30'h00000080; read_write = RD;
            address_strobe_ = (c == 0 || c == 5) ? 1'b0 : 1'b1;
            bus_grant_ = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
            bus_ready_ = (c == 3) ? 1'b0 : 1'b1;
            bus_read_data = (c == 3) ? 32'hCAFEF00D : 32'h0;
            stall = (c >= 3 && c <= 5) ? 1'b1 : 1'b0;
            @(negedge clock);
            chk($sformatf("br_rdata_c%0d", c), read_data,
                (c >= 3 && c <= 6) ? 32'hCAFEF00D : 32'h0);
            chk($sformatf("br_busy_c%0d", c), {31'h0, busy}, (c <= 2) ? 32'h1 : 32'h0);
            if (c == 4) chk("br_as_rel", {31'h0, bus_address_strobe_}, 32'h1);
            if (c == 6) chk("br_no_relaunch", {31'h0, bus_request_}, 32'h1);
            tick();
        end
        bus_grant_ = 1'b1; bus_ready_ = 1'b1; stall = 1'b0;

        // Flush in REQUEST, then flush+stall in IDLE.
        for (int c = 0; c < 6; c++) begin
            address = 30'h00000040; read_write = RD;
            address_strobe_ = (c == 0 || c == 4) ? 1'b0 : 1'b1;
            flush = (c == 1 || c == 4) ? 1'b1 : 1'b0;
            stall = (c == 4) ? 1'b1 : 1'b0;
            bus_grant_ = (c == 2) ? 1'b0 : 1'b1;
            @(negedge clock);
            if (c == 1) chk("fr_req", {31'h0, bus_request_}, 32'h0);
            if (c == 2) chk("fr_req_rel", {31'h0, bus_request_}, 32'h1);
            if (c == 3) chk("fr_no_as", {31'h0, bus_address_strobe_}, 32'h1);
            if (c == 4) chk("fi_busy", {31'h0, busy}, 32'h0);
            if (c == 5) chk("fi_no_req", {31'h0, bus_request_}, 32'h1);
            tick();
        end
        flush = 1'b0; stall = 1'b0; bus_grant_ = 1'b1;

        // Flush during ACCESS is ignored; transfer completes on ready.
        for (int c = 0; c < 6; c++) begin
            address = 30'h00000044; read_write = RD;
            address_strobe_ = (c == 0) ? 1'b0 : 1'b1;
            bus_grant_ = (c >= 1 && c <= 4) ? 1'b0 : 1'b1;
            flush = (c == 2 || c == 3) ? 1'b1 : 1'b0;
            bus_ready_ = (c == 4) ? 1'b0 : 1'b1;
            bus_read_data = (c == 4) ? 32'h55AA55AA : 32'h0;
            @(negedge clock);
            if (c == 3) begin
                chk("fa_as", {31'h0, bus_address_strobe_}, 32'h0);
                chk("fa_busy", {31'h0, busy}, 32'h1);
            end
            if (c == 4) begin
                chk("fa_rdata", read_data, 32'h55AA55AA);
                chk("fa_busy_done", {31'h0, busy}, 32'h0);
            end
            if (c == 5) begin
                chk("fa_req_rel", {31'h0, bus_request_}, 32'h1);
                chk("fa_rdata_idle", read_data, 32'h0);
            end
            tick();
        end
        flush = 1'b0; bus_grant_ = 1'b1; bus_ready_ = 1'b1;

        // Synchronous reset mid-ACCESS abandons the transfer.
        for (int c = 0; c < 5; c++) begin
            address = 30'h00000048; read_write = WR; write_data = 32'h0BADCAFE;
            address_strobe_ = (c == 0) ? 1'b0 : 1'b1;
            bus_grant_ = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
            reset = (c == 3) ? 1'b1 : 1'b0;
            @(negedge clock);
            if (c == 2) chk("ra_as", {31'h0, bus_address_strobe_}, 32'h0);
            if (c == 4) begin
                chk("ra_req", {31'h0, bus_request_}, 32'h1);
                chk("ra_as_rel", {31'h0, bus_address_strobe_}, 32'h1);
                chk("ra_busy", {31'h0, busy}, 32'h0);
                chk("ra_baddr", {2'b00, bus_address}, 32'h0);
                chk("ra_bwd", bus_write_data, 32'h0);
            end
            tick();
        end
        // A fresh access launches at once, showing the FSM is back in IDLE.
        address_strobe_ = 1'b0; address = 30'h0000004C;
        @(negedge clock);
        chk("ra_idle_launch", {31'h0, busy}, 32'h1);
        tick();
        address_strobe_ = 1'b1;
        @(negedge clock);
        chk("ra_idle_req", {31'h0, bus_request_}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
